oam_dma: RTL
============

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL expose parameter P_TRIGGER_ADDR, default 16'h4014, the CPU write address that starts a transfer.
REQ-002 SHALL expose parameter P_TARGET_ADDR, default 16'h2004, the write address for every transferred byte.
REQ-003 SHALL have port I_clock, input, 1, system clock; the block has one clock.
REQ-004 SHALL have port I_reset, input, 1, reset; synchronous, active-low.
REQ-005 SHALL have port I_cycle, input, 1, one-clock strobe marking the last clock of each CPU bus cycle; free-running, independent of CPU halt.
REQ-006 SHALL have ports I_cpu_addr (in, 16), I_cpu_wr_data (in, 8), I_cpu_rdwr (in, 1, 1=read), carrying the core's bus request.
REQ-007 SHALL have port I_bus_rd_data, input, 8, read data from the system bus.
REQ-008 SHALL have ports O_bus_addr (out, 16), O_bus_wr_data (out, 8), O_bus_rdwr (out, 1, 1=read), carrying the muxed bus request to memory.
REQ-009 SHALL have port O_cpu_ready, output, 1, which drives the core's I_ready; 0 = CPU halted.
REQ-010 SHALL have port O_busy, output, 1, high whenever state is not IDLE.

Function
REQ-011 "Cycle" SHALL mean the span between I_cycle strobes; all state, index, data and parity updates SHALL occur only on clocks where I_cycle=1.
REQ-012 States SHALL be IDLE, HALT, ALIGN, READ, WRITE.
REQ-013 Parity bit `put` SHALL toggle on every I_cycle strobe in every state; READ cycles SHALL only occur with put=0 and WRITE cycles only with put=1.
REQ-014 In IDLE, a strobe with I_cpu_rdwr=0 and I_cpu_addr==P_TRIGGER_ADDR SHALL latch page=I_cpu_wr_data, clear idx to 0, and enter HALT.
REQ-015 In IDLE, CPU reads of P_TRIGGER_ADDR and writes to any other address SHALL have no effect.
REQ-016 O_cpu_ready SHALL be 1 in IDLE and 0 in every other state, decoded combinationally from the registered state.
REQ-017 In IDLE and HALT, O_bus_* SHALL forward I_cpu_* unchanged.
REQ-018 In HALT, a strobe with I_cpu_rdwr=1 SHALL go to READ if the next cycle has put=0, else to ALIGN; a strobe with I_cpu_rdwr=0 SHALL remain in HALT.
REQ-019 In ALIGN, the bus SHALL forward the CPU request (dummy read), and the strobe SHALL go to READ.
REQ-020 In READ, O_bus_addr SHALL be {page, idx} and O_bus_rdwr=1; the strobe SHALL latch I_bus_rd_data into the data register and go to WRITE.
REQ-021 In WRITE, O_bus_addr SHALL be P_TARGET_ADDR, O_bus_wr_data the data register, and O_bus_rdwr=0; the strobe SHALL increment idx modulo 256.
REQ-022 In WRITE, if idx was 8'hFF the strobe SHALL go to IDLE; otherwise it SHALL go to READ.
REQ-023 Transfer length SHALL be exactly 256 bytes, from {page,8'h00} through {page,8'hFF}, in ascending order, with no page carry.
REQ-024 Total halted duration SHALL be 513 cycles when the halt lands on a write-capable alignment (no ALIGN) and 514 cycles with ALIGN: 1 HALT + optional 1 ALIGN + 512.
REQ-025 Trigger writes SHALL be ignored while O_busy=1, with no restart and no page change.
REQ-026 O_bus_wr_data SHALL equal I_cpu_wr_data outside WRITE.

Reset
REQ-027 On a clock with I_reset=0, the block SHALL enter IDLE and clear page, idx and data to 0 and put to 0 (next cycle is get).
REQ-028 Reset SHALL take effect regardless of I_cycle, and SHALL abort any transfer mid-operation.
REQ-029 After reset, O_cpu_ready=1, O_busy=0, and O_bus_* SHALL forward I_cpu_*.

Verification
REQ-030 Write 8'h02 to 16'h4014, then CPU read on a cycle with put=1 -> no ALIGN; bus reads 0200..02FF, each followed by a write to 2004 of the same data; O_cpu_ready low for exactly 513 cycles.
REQ-031 Same as REQ-030 with parity shifted by one cycle -> one ALIGN cycle forwarding the CPU read; ready low for exactly 514 cycles.
REQ-032 CPU performs two writes after the trigger (HALT + I_cpu_rdwr=0) -> stays HALT with the CPU writes forwarded; DMA starts only after the first CPU read cycle.
REQ-033 Write 8'h07 to 16'h4014 during an active page-03 transfer -> ignored; source stays 03xx and the count remains 256.
REQ-034 Assert I_reset=0 at idx=8'h40 in WRITE -> next clock IDLE, O_cpu_ready=1, O_busy=0, and bus forwards the CPU.
REQ-035 Write to 16'h4015 and read of 16'h4014 -> no transfer; O_busy stays 0.

Source files
------------

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
//
// Sprite (OAM) DMA engine. A CPU write of the page number to P_TRIGGER_ADDR
// halts the CPU and copies 256 bytes from {page, 8'h00}..{page, 8'hFF} to
// P_TARGET_ADDR, one read cycle followed by one write cycle per byte. Reads
// only happen on "get" cycles (put=0) and writes only on "put" cycles
// (put=1); when the CPU's first halted read lands on the wrong parity, one
// ALIGN cycle (forwarded CPU dummy read) is inserted.
//
// Ports
//   I_clock        system clock
//   I_reset        synchronous reset, active low
//   I_cycle        one-clock strobe on the last clock of each CPU bus cycle
//   I_cpu_addr     CPU bus address
//   I_cpu_wr_data  CPU write data
//   I_cpu_rdwr     CPU direction, 1 = read
//   I_bus_rd_data  read data returned by the system bus
//   O_bus_addr     address driven to the system bus
//   O_bus_wr_data  write data driven to the system bus
//   O_bus_rdwr     direction driven to the system bus, 1 = read
//   O_cpu_ready    CPU ready (0 = CPU halted)
//   O_busy         high whenever a transfer is pending or running
// -----------------------------------------------------------------------------
module oam_dma #(
    parameter logic [15:0] P_TRIGGER_ADDR = 16'h4014,
    parameter logic [15:0] P_TARGET_ADDR  = 16'h2004
) (
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_cycle,
    input  logic [15:0] I_cpu_addr,
    input  logic [7:0]  I_cpu_wr_data,
    input  logic        I_cpu_rdwr,
    input  logic [7:0]  I_bus_rd_data,
    output logic [15:0] O_bus_addr,
    output logic [7:0]  O_bus_wr_data,
    output logic        O_bus_rdwr,
    output logic        O_cpu_ready,
    output logic        O_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_e;

    state_e      state_q, state_d;
    logic        put_q,   put_d;
    logic [7:0]  page_q,  page_d;
    logic [7:0]  idx_q,   idx_d;
    logic [7:0]  data_q,  data_d;

    // State and datapath registers
    always_ff @(posedge I_clock) begin
        if (!I_reset) begin
            state_q <= S_IDLE;
            put_q   <= 1'b0;
            page_q  <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            put_q   <= put_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic: everything advances only on the cycle strobe
    always_comb begin
        state_d = state_q;
        put_d   = put_q;
        page_d  = page_q;
        idx_d   = idx_q;
        data_d  = data_q;
        if (I_cycle) begin
            put_d = ~put_q;
            unique case (state_q)
                S_IDLE: begin
                    if (!I_cpu_rdwr && (I_cpu_addr == P_TRIGGER_ADDR)) begin
                        page_d  = I_cpu_wr_data;
                        idx_d   = '0;
                        state_d = S_HALT;
                    end
                end
                S_HALT: begin
                    // CPU only actually stops on a read. The next cycle has
                    // parity ~put_q; a read needs put=0 there, otherwise burn
                    // one ALIGN cycle first.
                    if (I_cpu_rdwr) begin
                        state_d = put_q ? S_READ : S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    state_d = S_READ;
                end
                S_READ: begin
                    data_d  = I_bus_rd_data;
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    idx_d   = idx_q + 8'd1;
                    state_d = (idx_q == 8'hFF) ? S_IDLE : S_READ;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state
    always_comb begin
        O_bus_addr    = I_cpu_addr;
        O_bus_wr_data = I_cpu_wr_data;
        O_bus_rdwr    = I_cpu_rdwr;
        O_cpu_ready   = (state_q == S_IDLE);
        O_busy        = (state_q != S_IDLE);
        unique case (state_q)
            S_READ: begin
                O_bus_addr = {page_q, idx_q};
                O_bus_rdwr = 1'b1;
            end
            S_WRITE: begin
                O_bus_addr    = P_TARGET_ADDR;
                O_bus_wr_data = data_q;
                O_bus_rdwr    = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule
